uart_fifo_iface: RTL

Parametrised memory-mapped UART controller with independent RX and TX FIFOs, sticky overflow flags, FIFO flush, occupancy reporting and a level-sensitive interrupt output. It sits in the hardware-register region of the SoC address map behind the core data bus. It instantiates the existing `uart_tx` and `uart_rx` serialisers. It is the successor to the fixed 8-entry RX-only-queue UART interface: it adds a TX queue, configurable depths and error and interrupt reporting.

---
 rtl/uart_fifo_iface.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_iface.sv
// Memory-mapped UART controller: RX and TX byte FIFOs behind a four-register
// bus window, sticky overflow flags, FIFO flush, occupancy and a level IRQ.
// The uart_tx / uart_rx serialisers are kept in this file so the block is
// self-contained.

module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;

  // Frame sequencer: latch {stop, data, start} on accept, shift one bit per baud period.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q == ST_IDLE) begin
      if (valid_i) begin
        shift_d = {1'b1, data_i, 1'b0};
        baud_d  = '0;
        bit_d   = '0;
        state_d = ST_SEND;
      end
    end else if (baud_q == CW'(DIV - 1)) begin
      baud_d  = '0;
      shift_d = {1'b1, shift_q[9:1]};
      bit_d   = bit_q + 4'd1;
      if (bit_q == 4'd9) state_d = ST_IDLE;
    end else begin
      baud_d = baud_q + CW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign tx_o    = (state_q == ST_SEND) ? shift_q[0] : 1'b1;
endmodule

module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]    sync_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic          valid_q, valid_d;
  logic          rx_s;

  assign rx_s = sync_q[1];

  // Receive sequencer: confirm start at mid-bit, then sample each bit at its centre.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~ready_i;
    case (state_q)
      ST_IDLE: if (!rx_s) begin
        baud_d  = '0;
        state_d = ST_START;
      end
      ST_START: if (baud_q == CW'(DIV / 2 - 1)) begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = rx_s ? ST_IDLE : ST_DATA;
      end else baud_d = baud_q + CW'(1);
      ST_DATA: if (baud_q == CW'(DIV - 1)) begin
        baud_d  = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = ST_STOP;
      end else baud_d = baud_q + CW'(1);
      default: if (baud_q == CW'(DIV - 1)) begin
        state_d = ST_IDLE;
        if (rx_s) begin
          valid_d = 1'b1;
          data_d  = shift_q;
        end
      end else baud_d = baud_q + CW'(1);
    endcase
  end

  // Input synchroniser and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

module uart_fifo_iface #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int RX_DEPTH  = 8,
  parameter int TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        irq_o,
  input  logic        rx_i,
  output logic        tx_o
);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_IRQ_EN = 2'd3;

  logic [7:0]   rx_mem [RX_DEPTH];
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [RAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [TAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [RAW:0] rx_cnt_q, rx_cnt_d;
  logic [TAW:0] tx_cnt_q, tx_cnt_d;
  logic         rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic [1:0]   irq_en_q, irq_en_d;
  logic         irq_q, irq_d, rvalid_q;
  logic [31:0]  rdata_q, rdata_d, status;

  logic       rx_valid, tx_ready, tx_idle;
  logic [7:0] rx_byte;
  logic [1:0] off;
  logic       rd_req, wr_req, rx_empty, rx_full, tx_empty, tx_full;
  logic       rx_flush, rx_pop, rx_push, tx_flush, tx_wr, tx_pop, tx_push;
  logic       unused_bits;

  assign unused_bits = ^{addr_i[15:4], addr_i[1:0], wdata_i[31:8]};

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .ready_i(1'b1),
    .valid_o(rx_valid), .data_o(rx_byte)
  );

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
    .clk(clk), .rst_n(rst_n), .valid_i(~tx_empty), .data_i(tx_mem[tx_rp_q]),
    .ready_o(tx_ready), .tx_o(tx_o)
  );

  assign off      = addr_i[3:2];
  assign rd_req   = req_i & ~we_i;
  assign wr_req   = req_i & we_i;
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == (RAW + 1)'(RX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == (TAW + 1)'(TX_DEPTH));
  assign tx_idle  = tx_empty & tx_ready;

  // A flush beats a same-cycle push; a pop frees room for a push on a full FIFO.
  assign rx_flush = wr_req & (off == OFF_CTRL) & wdata_i[2];
  assign tx_flush = wr_req & (off == OFF_CTRL) & wdata_i[3];
  assign rx_pop   = rd_req & (off == OFF_DATA) & ~rx_empty;
  assign rx_push  = rx_valid & ~rx_flush & (~rx_full | rx_pop);
  assign tx_wr    = wr_req & (off == OFF_DATA);
  assign tx_pop   = ~tx_empty & tx_ready;
  assign tx_push  = tx_wr & ~tx_flush & (~tx_full | tx_pop);

  assign status = {8'h00, 8'(tx_cnt_q), 8'(rx_cnt_q), 3'b000,
                   tx_ovf_q, rx_ovf_q, tx_idle, ~rx_empty, tx_full};

  // Next-state for FIFO pointers/counts, sticky flags, IRQ enable and read data.
  always_comb begin
    rx_wp_d  = rx_push ? rx_wp_q + RAW'(1) : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + RAW'(1) : rx_rp_q;
    rx_cnt_d = rx_cnt_q + (RAW + 1)'(rx_push) - (RAW + 1)'(rx_pop);
    tx_wp_d  = tx_push ? tx_wp_q + TAW'(1) : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + TAW'(1) : tx_rp_q;
    tx_cnt_d = tx_cnt_q + (TAW + 1)'(tx_push) - (TAW + 1)'(tx_pop);
    if (rx_flush) begin
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = '0;
    end
    if (tx_flush) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
    end
    rx_ovf_d = (rx_valid & ~rx_flush & rx_full & ~rx_pop) |
               (rx_ovf_q & ~(wr_req & (off == OFF_CTRL) & wdata_i[0]));
    tx_ovf_d = (tx_wr & ~tx_flush & tx_full & ~tx_pop) |
               (tx_ovf_q & ~(wr_req & (off == OFF_CTRL) & wdata_i[1]));
    irq_en_d = (wr_req && off == OFF_IRQ_EN) ? wdata_i[1:0] : irq_en_q;
    irq_d    = (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_idle);
    rdata_d  = '0;
    if (rd_req) begin
      case (off)
        OFF_DATA:   rdata_d = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_mem[rx_rp_q]};
        OFF_STATUS: rdata_d = status;
        OFF_IRQ_EN: rdata_d = {30'h0, irq_en_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  // Control and bus-response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      rvalid_q <= req_i;
      rdata_q  <= rdata_d;
    end
  end

  // FIFO storage writes.
  // NOTE: storage arrays are not reset; the counts alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp_q] <= rx_byte;
    if (tx_push) tx_mem[tx_wp_q] <= wdata_i[7:0];
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign irq_o    = irq_q;
endmodule
